// File: rtl/debounce_edge_detect.sv
// Debounce filter with edge detection and a rising-edge event counter.
// Takes the output of the two-flop synchronizer and removes bounce and glitches.
// A change is committed only after DEBOUNCE_CYCLES consecutive samples that
// differ from the current level.
// On a commit the block updates the clean level and emits a one-cycle rise or
// fall pulse. Each rise also increments a wrapping event counter.
// Optional feature: define DEBOUNCE_IRQ_EN to add a sticky irq flag and its
// irq_clr input.
module debounce_edge_detect #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_sync,
`ifdef DEBOUNCE_IRQ_EN
    input  logic             irq_clr,
    output logic             irq,
`endif
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] event_cnt
);

    localparam int STAB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic              level_q, level_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic [CNT_W-1:0]  event_cnt_q, event_cnt_d;

    // State and output registers; reset overrides any check in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE_LO;
            stab_cnt_q  <= '0;
            level_q     <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            event_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stab_cnt_q  <= stab_cnt_d;
            level_q     <= level_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            event_cnt_q <= event_cnt_d;
        end
    end

    // Next-state logic; pulses default low so each commit yields exactly one
    always_comb begin
        state_d     = state_q;
        stab_cnt_d  = stab_cnt_q;
        level_d     = level_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        event_cnt_d = event_cnt_q;
        unique case (state_q)
            IDLE_LO: begin
                if (in_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        level_d     = 1'b1;
                        rise_d      = 1'b1;
                        event_cnt_d = event_cnt_q + CNT_W'(1);
                        stab_cnt_d  = '0;
                        state_d     = IDLE_HI;
                    end else begin
                        stab_cnt_d = STAB_W'(1);
                        state_d    = CHK_HI;
                    end
                end
            end
            CHK_HI: begin
                if (!in_sync) begin
                    stab_cnt_d = '0;
                    state_d    = IDLE_LO;
                end else if (stab_cnt_q == STAB_LAST) begin
                    level_d     = 1'b1;
                    rise_d      = 1'b1;
                    event_cnt_d = event_cnt_q + CNT_W'(1);
                    stab_cnt_d  = '0;
                    state_d     = IDLE_HI;
                end else begin
                    stab_cnt_d = stab_cnt_q + STAB_W'(1);
                end
            end
            IDLE_HI: begin
                if (!in_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        level_d    = 1'b0;
                        fall_d     = 1'b1;
                        stab_cnt_d = '0;
                        state_d    = IDLE_LO;
                    end else begin
                        stab_cnt_d = STAB_W'(1);
                        state_d    = CHK_LO;
                    end
                end
            end
            CHK_LO: begin
                if (in_sync) begin
                    stab_cnt_d = '0;
                    state_d    = IDLE_HI;
                end else if (stab_cnt_q == STAB_LAST) begin
                    level_d    = 1'b0;
                    fall_d     = 1'b1;
                    stab_cnt_d = '0;
                    state_d    = IDLE_LO;
                end else begin
                    stab_cnt_d = stab_cnt_q + STAB_W'(1);
                end
            end
            default: begin
                stab_cnt_d = '0;
                state_d    = IDLE_LO;
            end
        endcase
    end

`ifdef DEBOUNCE_IRQ_EN
    logic irq_q, irq_d;

    // Sticky edge flag; a new edge takes priority over a simultaneous clear
    always_comb begin
        irq_d = irq_q;
        if (rise_d || fall_d) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    // irq flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    assign level     = level_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign event_cnt = event_cnt_q;

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Testbench for debounce_edge_detect.
// dut uses N=4 with a 16-bit counter, and dut2 uses N=2 with a 4-bit counter
// to exercise counter wrap.
// With DEBOUNCE_IRQ_EN defined, the irq scenario is also exercised.
module tb_debounce_edge_detect;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_sync = 1'b0;
    logic        level, rise, fall;
    logic [15:0] event_cnt;

    logic        reset2 = 1'b1;
    logic        in_sync2 = 1'b0;
    logic        level2, rise2, fall2;
    logic [3:0]  event_cnt2;

`ifdef DEBOUNCE_IRQ_EN
    logic        irq_clr = 1'b0;
    logic        irq_clr2 = 1'b0;
    logic        irq, irq2;
`endif

    int total = 0;
    int bad = 0;

    // Reference model state, independent of the DUT's FSM structure
    logic        mLevel = 1'b0;
    logic        mRise = 1'b0;
    logic        mFall = 1'b0;
    logic [15:0] mCnt = '0;
    int          mRun = 0;

    logic [18:0] sb[$];
    logic [18:0] exp;
    logic [18:0] got;

    debounce_edge_detect #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk),
        .reset(reset),
        .in_sync(in_sync),
`ifdef DEBOUNCE_IRQ_EN
        .irq_clr(irq_clr),
        .irq(irq),
`endif
        .level(level),
        .rise(rise),
        .fall(fall),
        .event_cnt(event_cnt)
    );

    debounce_edge_detect #(.DEBOUNCE_CYCLES(2), .CNT_W(4)) dut2 (
        .clk(clk),
        .reset(reset2),
        .in_sync(in_sync2),
`ifdef DEBOUNCE_IRQ_EN
        .irq_clr(irq_clr2),
        .irq(irq2),
`endif
        .level(level2),
        .rise(rise2),
        .fall(fall2),
        .event_cnt(event_cnt2)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    // Drive one sample into dut, push the model's expectation, and wait for the edge
    task automatic drive(input logic inVal, input logic rstVal);
        in_sync = inVal;
        reset   = rstVal;
        if (rstVal) begin
            mLevel = 1'b0; mRise = 1'b0; mFall = 1'b0; mCnt = '0; mRun = 0;
        end else begin
            mRise = 1'b0;
            mFall = 1'b0;
            if (inVal != mLevel) begin
                mRun++;
                if (mRun == 4) begin
                    mRun   = 0;
                    mLevel = inVal;
                    if (inVal) begin
                        mRise = 1'b1;
                        mCnt  = mCnt + 16'd1;
                    end else begin
                        mFall = 1'b1;
                    end
                end
            end else begin
                mRun = 0;
            end
        end
        sb.push_back({mLevel, mRise, mFall, mCnt});
        @(posedge clk);
        #1;
    endtask

    // Reset state, then test 1: a held high input commits on the 4th edge
    task automatic test_reset_and_rise();
        drive(1'b0, 1'b1);
        exp = sb.pop_front();
        got = {level, rise, fall, event_cnt};
        total++;
        if (got !== 19'd0) begin
            bad++;
            $display("[TB] FAIL reset_state: got=%h want=%h", got, 19'd0);
        end
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b0);
            exp = sb.pop_front();
            got = {level, rise, fall, event_cnt};
            total++;
            if (got !== exp || rise !== (i == 4) || level !== (i >= 4)) begin
                bad++;
                $display("[TB] FAIL rise_edge%0d: got=%h want=%h", i, got, exp);
            end
        end
    endtask

    // Test 2: three high samples then low never commits
    task automatic test_short_glitch();
        drive(1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            drive((i < 3), 1'b0);
            exp = sb.pop_front();
            got = {level, rise, fall, event_cnt};
            total++;
            if (got !== exp || level !== 1'b0 || rise !== 1'b0 || event_cnt !== 16'd0) begin
                bad++;
                $display("[TB] FAIL glitch%0d: got=%h want=%h", i, got, exp);
            end
        end
    endtask

    // Test 3: from level high, four low samples give one fall pulse
    task automatic test_fall();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0);
            void'(sb.pop_front());
        end
        for (int i = 1; i <= 6; i++) begin
            drive(1'b0, 1'b0);
            exp = sb.pop_front();
            got = {level, rise, fall, event_cnt};
            total++;
            if (got !== exp || fall !== (i == 4) || event_cnt !== 16'd1) begin
                bad++;
                $display("[TB] FAIL fall_edge%0d: got=%h want=%h", i, got, exp);
            end
        end
    endtask

    // Test 5: reset in the middle of a check restarts the count
    task automatic test_reset_midcheck();
        drive(1'b1, 1'b0);
        void'(sb.pop_front());
        drive(1'b1, 1'b0);
        void'(sb.pop_front());
        drive(1'b1, 1'b1);
        exp = sb.pop_front();
        got = {level, rise, fall, event_cnt};
        total++;
        if (got !== 19'd0 || exp !== 19'd0) begin
            bad++;
            $display("[TB] FAIL midcheck_reset: got=%h want=%h", got, 19'd0);
        end
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b0);
            exp = sb.pop_front();
            got = {level, rise, fall, event_cnt};
            total++;
            if (got !== exp || rise !== (i == 4)) begin
                bad++;
                $display("[TB] FAIL after_reset%0d: got=%h want=%h", i, got, exp);
            end
        end
    endtask

    // Back-to-back random bouncy input against the reference model
    task automatic test_back_to_back();
        logic v;
        v = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 5) == 0) v = ~v;
            drive(v, 1'b0);
            exp = sb.pop_front();
            got = {level, rise, fall, event_cnt};
            total++;
            if (got !== exp || (rise && fall)) begin
                bad++;
                $display("[TB] FAIL random%0d: got=%h want=%h", i, got, exp);
            end
        end
    endtask

    // Test 4: N=2, 4-bit counter wraps after 16 rises
    task automatic test_wrap();
        logic [3:0] want;
        reset2 = 1'b1;
        @(posedge clk); #1;
        reset2 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            in_sync2 = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            want = 4'(k);
            total++;
            if (event_cnt2 !== want || rise2 !== 1'b1 || level2 !== 1'b1) begin
                bad++;
                $display("[TB] FAIL wrap_rise%0d: cnt=%0d rise=%b want cnt=%0d rise=1",
                         k, event_cnt2, rise2, want);
            end
            in_sync2 = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
    endtask

`ifdef DEBOUNCE_IRQ_EN
    // Test 6: irq set by edges, set wins over clear, clear alone drops it
    task automatic test_irq();
        drive(1'b0, 1'b1);
        void'(sb.pop_front());
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL irq_reset: got=%b want=0", irq);
        end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0);
            void'(sb.pop_front());
            total++;
            if (irq !== (i == 4)) begin
                bad++;
                $display("[TB] FAIL irq_rise%0d: got=%b want=%b", i, irq, (i == 4));
            end
        end
        for (int i = 1; i <= 4; i++) begin
            irq_clr = (i == 4);
            drive(1'b0, 1'b0);
            void'(sb.pop_front());
        end
        total++;
        if (irq !== 1'b1 || fall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL irq_set_wins: irq=%b fall=%b want irq=1 fall=1", irq, fall);
        end
        irq_clr = 1'b1;
        drive(1'b0, 1'b0);
        void'(sb.pop_front());
        irq_clr = 1'b0;
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL irq_clear: got=%b want=0", irq);
        end
    endtask
`endif

    // Run all scenarios in sequence and print the summary
    initial begin
        @(posedge clk); #1;
        test_reset_and_rise();
        test_short_glitch();
        test_fall();
        test_reset_midcheck();
        test_back_to_back();
        test_wrap();
`ifdef DEBOUNCE_IRQ_EN
        test_irq();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
